// File: rtl/icache_fetch_requester_pkg.sv
// Shared types and geometry for the fetch-side icache requester.
// Line size follows the CACHELINE_SIZE macro, falling back to 64 bytes.
`ifndef CACHELINE_SIZE
`define CACHELINE_SIZE 64
`endif

package icache_fetch_requester_pkg;

  localparam int VADDR_W     = 39;
  localparam int LINE_BYTES  = `CACHELINE_SIZE;
  localparam int FETCH_BYTES = 16;
  localparam int OFF_W       = $clog2(LINE_BYTES);
  localparam int BLK_W       = VADDR_W - OFF_W;
  localparam int LINE_W      = LINE_BYTES * 8;

  typedef struct packed {
    logic [VADDR_W-1:0] pc;
    logic               get2;
  } fetch_meta_t;

  typedef struct packed {
    logic [VADDR_W-1:0] pc;
    logic               get2;
    logic [LINE_W-1:0]  line0;
    logic [LINE_W-1:0]  line1;
  } fetch_pkt_t;

  // A fetch window starting at this line offset spills into the next line.
  function automatic logic needs_get2(input logic [OFF_W-1:0] off);
    logic [OFF_W:0] end_off;
    end_off = {1'b0, off} + (OFF_W+1)'(FETCH_BYTES);
    return (end_off > (OFF_W+1)'(LINE_BYTES));
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and
// synchronous flush; used for both request metadata and fetch packets.
module fetch_sync_fifo #(
  parameter type T      = logic,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/icache_fetch_requester.sv
// Fetch PC owner and master end of the core-to-icache request/response protocol:
// credit-limited issue, in-order response pairing, redirect squash, decode packet buffer.
module icache_fetch_requester
  import icache_fetch_requester_pkg::*;
#(
  parameter int                 BUF_DEPTH = 4,
  parameter logic [VADDR_W-1:0] RESET_PC  = 39'h80000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [VADDR_W-1:0] redirect_pc,
  output logic               icache_req,
  input  logic               icache_gnt,
  output logic [BLK_W-1:0]   icache_addr,
  output logic               icache_get2,
  input  logic               icache_rsp,
  input  logic [LINE_W-1:0]  icache_line0,
  input  logic [LINE_W-1:0]  icache_line1,
  output logic               out_valid,
  input  logic               out_ready,
  output fetch_pkt_t         out_pkt
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [VADDR_W-1:0] pc_q;
  logic [VADDR_W-1:0] pc_d;
  logic [CNT_W-1:0]   kill_q;
  logic [CNT_W-1:0]   kill_d;
  logic [CNT_W-1:0]   meta_cnt_s;
  logic [CNT_W-1:0]   pkt_cnt_s;
  logic               credit_ok_s;
  logic               meta_push_s;
  logic               meta_empty_s;
  logic               meta_full_s;
  logic               drop_s;
  logic               pkt_push_s;
  logic               pkt_pop_s;
  logic               pkt_empty_s;
  logic               pkt_full_s;
  fetch_meta_t        meta_in_s;
  fetch_meta_t        meta_head_s;
  fetch_pkt_t         pkt_in_s;

  assign icache_addr = pc_q[VADDR_W-1:OFF_W];
  assign icache_get2 = needs_get2(pc_q[OFF_W-1:0]);

  // Squashed-but-unreturned requests still hold credit until their rsp arrives.
  assign credit_ok_s = ({1'b0, meta_cnt_s} + {1'b0, pkt_cnt_s}) < (CNT_W+1)'(BUF_DEPTH);
  assign icache_req  = rst & fetch_en & ~redirect & credit_ok_s;
  assign meta_push_s = icache_req & icache_gnt;
  assign meta_in_s   = {pc_q, icache_get2};

  assign drop_s     = redirect | (kill_q != {CNT_W{1'b0}});
  assign pkt_push_s = icache_rsp & ~drop_s;
  assign pkt_in_s   = {meta_head_s.pc, meta_head_s.get2, icache_line0, icache_line1};
  assign out_valid  = ~pkt_empty_s;
  assign pkt_pop_s  = out_valid & out_ready;

  fetch_sync_fifo #(.T(fetch_meta_t), .DEPTH(BUF_DEPTH)) u_meta_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (1'b0),
    .push_i  (meta_push_s),
    .data_i  (meta_in_s),
    .pop_i   (icache_rsp),
    .data_o  (meta_head_s),
    .empty_o (meta_empty_s),
    .full_o  (meta_full_s),
    .count_o (meta_cnt_s)
  );

  fetch_sync_fifo #(.T(fetch_pkt_t), .DEPTH(BUF_DEPTH)) u_pkt_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (redirect),
    .push_i  (pkt_push_s),
    .data_i  (pkt_in_s),
    .pop_i   (pkt_pop_s),
    .data_o  (out_pkt),
    .empty_o (pkt_empty_s),
    .full_o  (pkt_full_s),
    .count_o (pkt_cnt_s)
  );

  // Next PC and kill count; on redirect every meta entry left after this cycle is doomed.
  always_comb begin
    pc_d   = pc_q;
    kill_d = kill_q;
    if (redirect) begin
      pc_d   = redirect_pc;
      kill_d = meta_cnt_s - {{(CNT_W-1){1'b0}}, icache_rsp};
    end else begin
      if (meta_push_s) begin
        pc_d = pc_q + VADDR_W'(FETCH_BYTES);
      end else begin
        pc_d = pc_q;
      end
      if (icache_rsp && (kill_q != {CNT_W{1'b0}})) begin
        kill_d = kill_q - CNT_W'(1);
      end else begin
        kill_d = kill_q;
      end
    end
  end

  // Fetch PC and outstanding-squash counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      kill_q <= {CNT_W{1'b0}};
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
    end
  end

`ifndef SYNTHESIS
  a_rsp_has_meta: assert property (@(posedge clk) disable iff (!rst)
    icache_rsp |-> !meta_empty_s);
  a_kill_bounded: assert property (@(posedge clk) disable iff (!rst)
    kill_q <= meta_cnt_s);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(pkt_push_s && pkt_full_s) && !(meta_push_s && meta_full_s));
`endif

endmodule

// File: tb/tb_icache_fetch_requester.sv
// Bench for icache_fetch_requester: a 3-stage icache responder plus a queue-based
// reference of outstanding requests and buffered packets.
module tb_icache_fetch_requester;
  import icache_fetch_requester_pkg::*;

  localparam int                 DEPTH    = 4;
  localparam logic [VADDR_W-1:0] START_PC = 39'h80000000;

  logic               clk = 1'b0;
  logic               rst;
  logic               fetch_en;
  logic               redirect;
  logic [VADDR_W-1:0] redirect_pc;
  logic               icache_req;
  logic               icache_gnt;
  logic [BLK_W-1:0]   icache_addr;
  logic               icache_get2;
  logic               icache_rsp;
  logic [LINE_W-1:0]  icache_line0;
  logic [LINE_W-1:0]  icache_line1;
  logic               out_valid;
  logic               out_ready;
  fetch_pkt_t         out_pkt;

  always #5 clk = ~clk;

  icache_fetch_requester dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .icache_req(icache_req), .icache_gnt(icache_gnt), .icache_addr(icache_addr),
    .icache_get2(icache_get2), .icache_rsp(icache_rsp), .icache_line0(icache_line0),
    .icache_line1(icache_line1), .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt)
  );

  typedef struct { logic [VADDR_W-1:0] pc; logic get2; bit wanted; } pend_t;
  pend_t              pend_q[$];
  fetch_pkt_t         outq[$];
  logic [VADDR_W-1:0] m_pc;
  bit                 s_v [3];
  logic [BLK_W-1:0]   s_a [3];
  logic               s_g [3];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  logic               exp_req, exp_get2, exp_valid;
  logic [BLK_W-1:0]   exp_addr;
  fetch_pkt_t         exp_pkt;

  function automatic logic [LINE_W-1:0] mkline(input logic [BLK_W-1:0] a);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = a[31:0] ^ (32'h9e3779b9 * i);
    return l;
  endfunction

  function automatic logic get2_of(input logic [VADDR_W-1:0] pc);
    return (int'(pc % LINE_BYTES) + FETCH_BYTES) > LINE_BYTES;
  endfunction

  function automatic logic [BLK_W-1:0] blk_of(input logic [VADDR_W-1:0] pc);
    return BLK_W'(pc / LINE_BYTES);
  endfunction

  task automatic drive_rsp();
    icache_rsp   = s_v[2];
    icache_line0 = s_v[2] ? mkline(s_a[2]) : {LINE_W{1'b0}};
    icache_line1 = (s_v[2] && s_g[2]) ? mkline(s_a[2] + BLK_W'(1)) : {LINE_W{1'b0}};
  endtask

  task automatic clear_model();
    pend_q.delete();
    outq.delete();
    m_pc = START_PC;
    for (int i = 0; i < 3; i++) begin s_v[i] = 1'b0; s_a[i] = '0; s_g[i] = 1'b0; end
    drive_rsp();
  endtask

  // Move to just before the active edge and compute the reference expectations.
  task automatic sample();
    @(negedge clk); #4;
    exp_valid = (outq.size() > 0);
    exp_pkt   = exp_valid ? outq[0] : '0;
    exp_req   = rst && fetch_en && !redirect && ((pend_q.size() + outq.size()) < DEPTH);
    exp_addr  = blk_of(m_pc);
    exp_get2  = get2_of(m_pc);
  endtask

  // Apply this cycle's events to the reference, cross the edge, drive the next rsp.
  task automatic advance();
    pend_t h;
    fetch_pkt_t p;
    bit g_v;
    logic [BLK_W-1:0] g_a;
    logic g_g;
    g_v = icache_req && icache_gnt;
    g_a = icache_addr;
    g_g = icache_get2;
    if (redirect) begin
      foreach (pend_q[i]) pend_q[i].wanted = 1'b0;
      outq.delete();
    end else if (out_ready && outq.size() > 0) begin
      void'(outq.pop_front());
    end
    if (icache_rsp && pend_q.size() > 0) begin
      h = pend_q.pop_front();
      if (h.wanted) begin
        p.pc    = h.pc;
        p.get2  = h.get2;
        p.line0 = mkline(blk_of(h.pc));
        p.line1 = h.get2 ? mkline(blk_of(h.pc) + BLK_W'(1)) : {LINE_W{1'b0}};
        outq.push_back(p);
      end
    end
    if (exp_req && icache_gnt) begin
      pend_q.push_back('{m_pc, exp_get2, 1'b1});
      m_pc = m_pc + VADDR_W'(FETCH_BYTES);
    end
    if (redirect) m_pc = redirect_pc;
    @(posedge clk); #1;
    s_v[2] = s_v[1]; s_a[2] = s_a[1]; s_g[2] = s_g[1];
    s_v[1] = s_v[0]; s_a[1] = s_a[0]; s_g[1] = s_g[0];
    s_v[0] = g_v;    s_a[0] = g_a;    s_g[0] = g_g;
    drive_rsp();
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
    icache_gnt = 1'b1; out_ready = 1'b0;
    clear_model();
    #1;
    n_cmp++; if (icache_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", icache_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b1; fetch_en = 1'b0;
    sample();
    n_cmp++; if (icache_addr !== blk_of(START_PC)) begin n_bad++; $display("FAIL reset_addr: got %0h expected %0h", icache_addr, blk_of(START_PC)); end
    n_cmp++; if (icache_get2 !== 1'b0) begin n_bad++; $display("FAIL reset_get2: got %b expected 0", icache_get2); end
    n_cmp++; if (icache_req !== 1'b0) begin n_bad++; $display("FAIL reset_req_off: got %b expected 0", icache_req); end
    advance();
  endtask

  task automatic test_stream();
    int first = -1;
    fetch_en = 1'b1; icache_gnt = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sample();
      n_cmp++; if (icache_req !== exp_req) begin n_bad++; $display("FAIL stream_req: got %b expected %b", icache_req, exp_req); end
      n_cmp++; if (icache_addr !== exp_addr) begin n_bad++; $display("FAIL stream_addr: got %0h expected %0h", icache_addr, exp_addr); end
      n_cmp++; if (out_valid !== exp_valid) begin n_bad++; $display("FAIL stream_valid: got %b expected %b", out_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (out_pkt !== exp_pkt) begin n_bad++; $display("FAIL stream_pkt: got pc %0h expected pc %0h", out_pkt.pc, exp_pkt.pc); end
      end
      if (out_valid && first < 0) begin
        first = c;
        n_cmp++; if (out_pkt.pc !== START_PC) begin n_bad++; $display("FAIL stream_first_pc: got %0h expected %0h", out_pkt.pc, START_PC); end
      end
      advance();
    end
    n_cmp++; if (first != 4) begin n_bad++; $display("FAIL stream_latency: got %0d expected 4", first); end
  endtask

  task automatic test_get2();
    bit seen = 1'b0;
    redirect = 1'b1; redirect_pc = 39'h1038;
    sample();
    n_cmp++; if (icache_req !== 1'b0) begin n_bad++; $display("FAIL get2_redir_req: got %b expected 0", icache_req); end
    advance();
    redirect = 1'b0;
    sample();
    n_cmp++; if (icache_addr !== 33'h40) begin n_bad++; $display("FAIL get2_addr: got %0h expected 40", icache_addr); end
    n_cmp++; if (icache_get2 !== 1'b1) begin n_bad++; $display("FAIL get2_flag: got %b expected 1", icache_get2); end
    advance();
    for (int c = 0; c < 12 && !seen; c++) begin
      sample();
      if (out_valid) begin
        seen = 1'b1;
        n_cmp++; if (out_pkt.pc !== 39'h1038 || out_pkt.get2 !== 1'b1) begin n_bad++; $display("FAIL get2_pkt: got pc %0h get2 %b expected pc 1038 get2 1", out_pkt.pc, out_pkt.get2); end
        n_cmp++; if (out_pkt.line1 !== mkline(33'h41)) begin n_bad++; $display("FAIL get2_line1: got %0h expected block 41 data", out_pkt.line1[31:0]); end
        n_cmp++; if (out_pkt !== exp_pkt) begin n_bad++; $display("FAIL get2_model: got pc %0h expected pc %0h", out_pkt.pc, exp_pkt.pc); end
      end
      advance();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL get2_timeout: got no packet expected one within 12 cycles"); end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    redirect = 1'b1; redirect_pc = 39'h2000; out_ready = 1'b0;
    sample(); advance();
    redirect = 1'b0;
    for (int c = 0; c < 14; c++) begin
      sample();
      n_cmp++; if (icache_req !== exp_req) begin n_bad++; $display("FAIL bp_req: got %b expected %b", icache_req, exp_req); end
      if (icache_req && icache_gnt) grants++;
      advance();
    end
    n_cmp++; if (grants != DEPTH) begin n_bad++; $display("FAIL bp_grants: got %0d expected %0d", grants, DEPTH); end
    out_ready = 1'b1;
    sample();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    advance();
    out_ready = 1'b0; grants = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (icache_req && icache_gnt) grants++;
      advance();
    end
    n_cmp++; if (grants != 1) begin n_bad++; $display("FAIL bp_refill: got %0d expected 1", grants); end
  endtask

  task automatic test_redirect_inflight();
    int first = -1;
    out_ready = 1'b1;
    repeat (2) begin sample(); advance(); end
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 39'h4_0000_0100;
    sample();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rd_pre_valid: got %b expected 1", out_valid); end
    advance();
    redirect = 1'b0; out_ready = 1'b1;
    for (int c = 1; c < 14; c++) begin
      sample();
      if (c == 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rd_flush: got %b expected 0", out_valid); end
      end
      n_cmp++; if (out_valid !== exp_valid) begin n_bad++; $display("FAIL rd_valid: got %b expected %b", out_valid, exp_valid); end
      if (out_valid && first < 0) begin
        first = c;
        n_cmp++; if (out_pkt.pc !== 39'h4_0000_0100) begin n_bad++; $display("FAIL rd_first_pc: got %0h expected 400000100", out_pkt.pc); end
      end
      advance();
    end
    n_cmp++; if (first < 4) begin n_bad++; $display("FAIL rd_first_cycle: got %0d expected >= 4", first); end
  endtask

  task automatic test_redirect_b2b();
    int first = -1;
    fetch_en = 1'b1; icache_gnt = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 12 && !(icache_rsp && c >= 6); c++) begin sample(); advance(); end
    redirect = 1'b1; redirect_pc = 39'h5000;
    sample(); advance();
    redirect_pc = 39'h6000;
    sample(); advance();
    redirect = 1'b0;
    for (int c = 0; c < 12; c++) begin
      sample();
      n_cmp++; if (out_valid !== exp_valid) begin n_bad++; $display("FAIL b2b_valid: got %b expected %b", out_valid, exp_valid); end
      if (out_valid && first < 0) begin
        first = c;
        n_cmp++; if (out_pkt.pc !== 39'h6000) begin n_bad++; $display("FAIL b2b_first_pc: got %0h expected 6000", out_pkt.pc); end
      end else if (exp_valid) begin
        n_cmp++; if (out_pkt !== exp_pkt) begin n_bad++; $display("FAIL b2b_pkt: got pc %0h expected pc %0h", out_pkt.pc, exp_pkt.pc); end
      end
      advance();
    end
    n_cmp++; if (dut.kill_q !== '0) begin n_bad++; $display("FAIL b2b_kill: got %0d expected 0", dut.kill_q); end
  endtask

  task automatic test_stall_and_reset();
    logic [BLK_W-1:0] a0;
    logic g0;
    bit seen = 1'b0;
    redirect = 1'b1; redirect_pc = 39'h7038; icache_gnt = 1'b1; out_ready = 1'b0;
    sample(); advance();
    redirect = 1'b0;
    repeat (8) begin sample(); advance(); end
    out_ready = 1'b1;
    sample(); advance();
    out_ready = 1'b0; icache_gnt = 1'b0;
    sample();
    a0 = icache_addr; g0 = icache_get2;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) sample();
      n_cmp++; if (icache_req !== 1'b1) begin n_bad++; $display("FAIL stall_req: got %b expected 1", icache_req); end
      n_cmp++; if (icache_addr !== a0 || icache_get2 !== g0) begin n_bad++; $display("FAIL stall_stable: got %0h/%b expected %0h/%b", icache_addr, icache_get2, a0, g0); end
      n_cmp++; if (icache_addr !== exp_addr) begin n_bad++; $display("FAIL stall_addr: got %0h expected %0h", icache_addr, exp_addr); end
      advance();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
    #2; rst = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b expected 0", out_valid); end
    n_cmp++; if (icache_req !== 1'b0) begin n_bad++; $display("FAIL async_req: got %b expected 0", icache_req); end
    clear_model();
    @(posedge clk); #1;
    rst = 1'b1; icache_gnt = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      sample();
      if (out_valid) begin
        seen = 1'b1;
        n_cmp++; if (out_pkt.pc !== START_PC) begin n_bad++; $display("FAIL post_reset_pc: got %0h expected %0h", out_pkt.pc, START_PC); end
      end
      advance();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL post_reset_timeout: got no packet expected one within 10 cycles"); end
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int c = 0; c < 400; c++) begin
      fetch_en   = ($urandom_range(0, 9) != 0);
      icache_gnt = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 1) != 0);
      redirect   = (c == 0) || ($urandom_range(0, 19) == 0);
      r = {$urandom(), $urandom()};
      redirect_pc = (c == 0) ? 39'h7F_FFFF_FFF8 : r[VADDR_W-1:0];
      redirect_pc[0] = 1'b0;
      sample();
      n_cmp++; if (icache_req !== exp_req) begin n_bad++; $display("FAIL rnd_req c%0d: got %b expected %b", c, icache_req, exp_req); end
      n_cmp++; if (icache_addr !== exp_addr || icache_get2 !== exp_get2) begin n_bad++; $display("FAIL rnd_addr c%0d: got %0h/%b expected %0h/%b", c, icache_addr, icache_get2, exp_addr, exp_get2); end
      n_cmp++; if (out_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, out_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (out_pkt !== exp_pkt) begin n_bad++; $display("FAIL rnd_pkt c%0d: got pc %0h get2 %b expected pc %0h get2 %b", c, out_pkt.pc, out_pkt.get2, exp_pkt.pc, exp_pkt.get2); end
      end
      advance();
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_get2();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_b2b();
    test_stall_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
